// File: rtl/intctl_if.sv
// intctl_if: bus bundle between the chad MCU core and the interrupt controller.
//   io_rd / io_wr   : decoded I/O strobes for this block
//   io_addr         : register select
//   din / io_dout   : write data / combinational read data
//   src             : external interrupt sources (already clk-synchronous)
//   irq / ivec      : registered interrupt request and vector (channel+1)
//   iack            : one-cycle acknowledge from the CPU
// master = CPU side (drives strobes, sources, iack); slave = intctl.
interface intctl_if #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4
);
    logic                io_rd;
    logic                io_wr;
    logic [2:0]          io_addr;
    logic [WIDTH-1:0]    din;
    logic [WIDTH-1:0]    io_dout;
    logic [CHANNELS-1:0] src;
    logic                irq;
    logic [3:0]          ivec;
    logic                iack;

    modport master (
        output io_rd, io_wr, io_addr, din, src, iack,
        input  io_dout, irq, ivec
    );

    modport slave (
        input  io_rd, io_wr, io_addr, din, src, iack,
        output io_dout, irq, ivec
    );
endinterface

// File: rtl/intctl.sv
// intctl: interrupt controller with CHANNELS external sources plus a built-in
// periodic timer on channel 0. Per-channel enable and edge/level mode, fixed
// priority (lowest channel wins), irq/ivec/iack handshake to the CPU.
// Ports:
//   clk  : single clock
//   arst : asynchronous active-high reset
//   bus  : intctl_if.slave (I/O strobes, address, data, sources, irq/ivec/iack)
// Register map (N = CHANNELS+1 bit fields):
//   0 EN, 1 MODE (1=edge, bit 0 ignored), 2 PEND (read / W1C on edge bits),
//   3 RELOAD (write also loads counter), 4 TCNT (RO), 5 CTRL {gie, run},
//   6-7 read as zero.
module intctl #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int TBITS    = 16
) (
    input  logic    clk,
    input  logic    arst,
    intctl_if.slave bus
);
    localparam int N = CHANNELS + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Architectural state
    logic [N-1:0]        en_r;
    logic [N-1:0]        mode_r;
    logic [N-1:0]        pend_r;
    logic [TBITS-1:0]    reload_r;
    logic [TBITS-1:0]    tcnt_r;
    logic                run_r;
    logic                gie_r;
    logic [CHANNELS-1:0] src_q_r;
    state_t              state_r;
    logic                irq_r;
    logic [3:0]          ivec_r;

    // Combinational helpers
    logic [7:0]          wr_sel_s;
    logic                expire_s;
    logic [TBITS-1:0]    tcnt_next_s;
    logic [N-1:0]        level_s;
    logic [N-1:0]        set_s;
    logic [N-1:0]        clr_s;
    logic [N-1:0]        ack_clr_s;
    logic [N-1:0]        pend_next_s;
    logic [N-1:0]        active_s;
    logic [3:0]          first_vec_s;
    logic                ack_s;
    state_t              state_next_s;
    logic                irq_next_s;
    logic [3:0]          ivec_next_s;
    logic [WIDTH-1:0]    rd_data_s;
    logic                unused_din_s;

    // Upper write-data bits beyond every field are intentionally ignored.
    assign unused_din_s = ^bus.din;

    // One-hot write decode of the register select.
    assign wr_sel_s = bus.io_wr ? (8'b0000_0001 << bus.io_addr) : 8'b0000_0000;

    // Software-visible configuration registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            en_r     <= {N{1'b0}};
            mode_r   <= {N{1'b0}};
            reload_r <= {TBITS{1'b1}};
            run_r    <= 1'b0;
            gie_r    <= 1'b0;
        end else begin
            if (wr_sel_s[0]) en_r     <= bus.din[N-1:0];
            if (wr_sel_s[1]) mode_r   <= bus.din[N-1:0];
            if (wr_sel_s[3]) reload_r <= bus.din[TBITS-1:0];
            if (wr_sel_s[5]) begin
                run_r <= bus.din[0];
                gie_r <= bus.din[1];
            end
        end
    end

    // Timer next count: a RELOAD write beats both expiry reload and decrement,
    // while expiry itself is still reported to the pending logic.
    always_comb begin
        expire_s = run_r && (tcnt_r == {TBITS{1'b0}});
        if (wr_sel_s[3]) begin
            tcnt_next_s = bus.din[TBITS-1:0];
        end else if (expire_s) begin
            tcnt_next_s = reload_r;
        end else if (run_r) begin
            tcnt_next_s = tcnt_r - {{(TBITS-1){1'b0}}, 1'b1};
        end else begin
            tcnt_next_s = tcnt_r;
        end
    end

    // Timer counter register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tcnt_r <= {TBITS{1'b0}};
        end else begin
            tcnt_r <= tcnt_next_s;
        end
    end

    // Pending next-state: level channels track src, edge channels (and the
    // timer, always edge) set on event and clear on W1C/iack, set winning.
    always_comb begin
        ack_s     = (state_r == ST_REQ) && bus.iack;
        ack_clr_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (ack_s && (ivec_r == 4'(i + 1))) begin
                ack_clr_s[i] = 1'b1;
            end else begin
                ack_clr_s[i] = 1'b0;
            end
        end
        level_s     = {~mode_r[N-1:1], 1'b0};
        set_s       = {bus.src & ~src_q_r, expire_s};
        clr_s       = (wr_sel_s[2] ? bus.din[N-1:0] : {N{1'b0}}) | ack_clr_s;
        pend_next_s = (level_s & {bus.src, 1'b0})
                    | (~level_s & (set_s | (pend_r & ~clr_s)));
    end

    // Pending bits and previous-cycle source samples for edge detection.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pend_r  <= {N{1'b0}};
            src_q_r <= {CHANNELS{1'b0}};
        end else begin
            pend_r  <= pend_next_s;
            src_q_r <= bus.src;
        end
    end

    // Lowest enabled pending channel gives the vector (channel 0 = highest).
    always_comb begin
        active_s    = pend_r & en_r;
        first_vec_s = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            first_vec_s = active_s[i] ? 4'(i + 1) : first_vec_s;
        end
    end

    // Arbiter state, irq and ivec registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= ST_IDLE;
            irq_r   <= 1'b0;
            ivec_r  <= 4'd0;
        end else begin
            state_r <= state_next_s;
            irq_r   <= irq_next_s;
            ivec_r  <= ivec_next_s;
        end
    end

    // Arbiter next state: once requested, only iack releases the request.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (gie_r && (|active_s)) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.iack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Arbiter outputs for the coming cycle: vector latched on entry, frozen in REQ.
    always_comb begin
        irq_next_s = (state_next_s == ST_REQ);
        case (state_r)
            ST_IDLE: begin
                if (state_next_s == ST_REQ) begin
                    ivec_next_s = first_vec_s;
                end else begin
                    ivec_next_s = 4'd0;
                end
            end
            ST_REQ: begin
                if (bus.iack) begin
                    ivec_next_s = 4'd0;
                end else begin
                    ivec_next_s = ivec_r;
                end
            end
            default: ivec_next_s = 4'd0;
        endcase
    end

    // Combinational read mux, forced to zero when not reading.
    always_comb begin
        rd_data_s = {WIDTH{1'b0}};
        if (bus.io_rd) begin
            case (bus.io_addr)
                3'd0: rd_data_s[N-1:0]     = en_r;
                3'd1: rd_data_s[N-1:0]     = mode_r;
                3'd2: rd_data_s[N-1:0]     = pend_r;
                3'd3: rd_data_s[TBITS-1:0] = reload_r;
                3'd4: rd_data_s[TBITS-1:0] = tcnt_r;
                3'd5: rd_data_s[1:0]       = {gie_r, run_r};
                default: rd_data_s         = {WIDTH{1'b0}};
            endcase
        end else begin
            rd_data_s = {WIDTH{1'b0}};
        end
    end

    assign bus.io_dout = rd_data_s;
    assign bus.irq     = irq_r;
    assign bus.ivec    = ivec_r;
endmodule

// File: tb/tb_intctl.sv
// tb_intctl: directed-vector bench for intctl. Stimulus pushes expected irq
// transitions (level, vector, cycle) and expected read data into queues; a
// negedge monitor pops and compares whenever the DUT presents an irq change
// or a register read.
module tb_intctl;
    localparam int WIDTH    = 18;
    localparam int CHANNELS = 4;
    localparam int TBITS    = 16;

    typedef struct {
        logic       lvl;
        logic [3:0] vec;
        int         cyc;
        string      name;
    } irq_exp_t;

    typedef struct {
        logic [WIDTH-1:0] val;
        string            name;
    } rd_exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   cyc  = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    irq_exp_t irq_q[$];
    rd_exp_t  rd_q[$];

    intctl_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    intctl #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .TBITS(TBITS)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic       prev_irq  = 1'b0;
    logic [3:0] prev_ivec = 4'd0;

    always @(negedge clk) begin
        irq_exp_t ie;
        rd_exp_t  re;
        if (arst) begin
            vectors++;
            if (bus.irq !== 1'b0 || bus.ivec !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_outputs @%0d: irq=%0b ivec=%0d, required irq=0 ivec=0",
                         cyc, bus.irq, bus.ivec);
            end
            prev_irq  = 1'b0;
            prev_ivec = 4'd0;
        end else begin
            if (bus.irq !== prev_irq) begin
                vectors++;
                if (irq_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL irq_unexpected @%0d: irq=%0b ivec=%0d, required no change",
                             cyc, bus.irq, bus.ivec);
                end else begin
                    ie = irq_q.pop_front();
                    if (bus.irq !== ie.lvl || bus.ivec !== ie.vec || cyc != ie.cyc) begin
                        miscompares++;
                        $display("FAIL %s: irq=%0b ivec=%0d cycle=%0d, required irq=%0b ivec=%0d cycle=%0d",
                                 ie.name, bus.irq, bus.ivec, cyc, ie.lvl, ie.vec, ie.cyc);
                    end
                end
            end else if (bus.irq === 1'b1) begin
                vectors++;
                if (bus.ivec !== prev_ivec) begin
                    miscompares++;
                    $display("FAIL ivec_frozen @%0d: ivec=%0d, required %0d", cyc, bus.ivec, prev_ivec);
                end
            end
            prev_irq  = bus.irq;
            prev_ivec = bus.ivec;

            if (bus.io_rd) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected @%0d: io_dout=%0h", cyc, bus.io_dout);
                end else begin
                    re = rd_q.pop_front();
                    if (bus.io_dout !== re.val) begin
                        miscompares++;
                        $display("FAIL %s @%0d: io_dout=%0h, required %0h",
                                 re.name, cyc, bus.io_dout, re.val);
                    end
                end
            end else begin
                vectors++;
                if (bus.io_dout !== {WIDTH{1'b0}}) begin
                    miscompares++;
                    $display("FAIL dout_idle @%0d: io_dout=%0h, required 0", cyc, bus.io_dout);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        bus.io_wr   = 1'b1;
        bus.io_addr = a;
        bus.din     = d;
        step(1);
        bus.io_wr   = 1'b0;
        bus.din     = {WIDTH{1'b0}};
    endtask

    task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] exp, input string name);
        rd_exp_t e;
        e.val  = exp;
        e.name = name;
        rd_q.push_back(e);
        bus.io_rd   = 1'b1;
        bus.io_addr = a;
        step(1);
        bus.io_rd   = 1'b0;
    endtask

    task automatic expect_irq(input logic lvl, input logic [3:0] vec, input int at, input string name);
        irq_exp_t e;
        e.lvl  = lvl;
        e.vec  = vec;
        e.cyc  = at;
        e.name = name;
        irq_q.push_back(e);
    endtask

    task automatic check_reset_regs(input string tag);
        logic [WIDTH-1:0] exp_tab [8];
        exp_tab = '{18'h0, 18'h0, 18'h0, 18'h0FFFF, 18'h0, 18'h0, 18'h0, 18'h0};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), exp_tab[a], $sformatf("%s_reg%0d", tag, a));
        end
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        int c;
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        bus.io_addr = 3'd0;
        bus.din     = {WIDTH{1'b0}};
        bus.src     = {CHANNELS{1'b0}};
        bus.iack    = 1'b0;

        step(3);
        arst = 1'b0;
        step(1);
        check_reset_regs("por");

        // Configure: all channels enabled, GIE, externals edge-mode.
        wr(3'd0, 18'h1F);
        wr(3'd5, 18'h02);
        wr(3'd1, 18'h1E);
        rd(3'd0, 18'h1F, "en_readback");
        rd(3'd5, 18'h02, "ctrl_readback");

        // 1: single edge on src[1] -> channel 2, ivec 3, two cycles later.
        c = cyc;
        bus.src = 4'b0010;
        expect_irq(1'b1, 4'd3, c + 2, "edge_src1_rise");
        step(1);
        bus.src = 4'b0000;
        goto(c + 2);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 3, "edge_src1_fall");
        step(1);
        bus.iack = 1'b0;
        rd(3'd2, 18'h00, "pend_after_iack");

        // 2: simultaneous edges on src[0], src[3] -> ivec 2 then 5.
        c = cyc;
        bus.src = 4'b1001;
        expect_irq(1'b1, 4'd2, c + 2, "prio_first");
        step(1);
        bus.src = 4'b0000;
        goto(c + 2);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 3, "prio_gap");
        expect_irq(1'b1, 4'd5, c + 4, "prio_second");
        step(1);
        bus.iack = 1'b0;
        goto(c + 4);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 5, "prio_second_fall");
        step(1);
        bus.iack = 1'b0;
        rd(3'd2, 18'h00, "pend_after_prio");

        // 3: channel 3 in level mode, src[2] held high.
        wr(3'd1, 18'h16);
        c = cyc;
        bus.src = 4'b0100;
        expect_irq(1'b1, 4'd4, c + 2, "level_rise");
        goto(c + 2);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 3, "level_gap");
        expect_irq(1'b1, 4'd4, c + 4, "level_reraise");
        rd(3'd2, 18'h08, "pend_level_high");
        bus.iack = 1'b0;
        goto(c + 4);
        bus.src  = 4'b0000;
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 5, "level_drop_fall");
        step(1);
        bus.iack = 1'b0;
        step(1);
        rd(3'd2, 18'h00, "pend_level_low");
        step(3);
        wr(3'd1, 18'h1E);

        // 4: timer, RELOAD=9 -> period 10; W1C at expiry loses to set.
        wr(3'd3, 18'd9);
        wr(3'd5, 18'h03);
        c = cyc;
        expect_irq(1'b1, 4'd1, c + 11, "timer_first");
        goto(c + 11);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 12, "timer_first_fall");
        step(1);
        bus.iack = 1'b0;
        expect_irq(1'b1, 4'd1, c + 21, "timer_second");
        goto(c + 21);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 22, "timer_second_fall");
        step(1);
        bus.iack = 1'b0;
        expect_irq(1'b1, 4'd1, c + 31, "timer_w1c_set_wins");
        goto(c + 29);
        wr(3'd2, 18'h01);
        rd(3'd2, 18'h01, "pend_w1c_at_expiry");
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 32, "timer_third_fall");
        rd(3'd4, 18'd8, "tcnt_after_reload");
        bus.iack = 1'b0;
        wr(3'd5, 18'h02);
        rd(3'd2, 18'h00, "pend_timer_stopped");

        // 5: masking a channel does not retract an active request.
        c = cyc;
        bus.src = 4'b0001;
        expect_irq(1'b1, 4'd2, c + 2, "mask_rise");
        step(1);
        bus.src = 4'b0000;
        goto(c + 2);
        wr(3'd0, 18'h00);
        rd(3'd0, 18'h00, "en_cleared");
        goto(c + 5);
        bus.iack = 1'b1;
        expect_irq(1'b0, 4'd0, c + 6, "mask_fall_on_iack");
        step(1);
        bus.iack = 1'b0;
        wr(3'd0, 18'h1F);

        // 6: arst mid-request drops irq asynchronously and clears everything.
        c = cyc;
        bus.src = 4'b0001;
        expect_irq(1'b1, 4'd2, c + 2, "arst_req_rise");
        step(1);
        bus.src = 4'b0000;
        goto(c + 3);
        arst = 1'b1;
        step(2);
        arst = 1'b0;
        step(1);
        check_reset_regs("arst");
        step(3);

        vectors++;
        if (irq_q.size() != 0) begin
            miscompares++;
            $display("FAIL irq_events_left: %0d outstanding, required 0", irq_q.size());
        end
        vectors++;
        if (rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL reads_left: %0d outstanding, required 0", rd_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/intctl.md
# intctl

Parametrised interrupt controller for the chad MCU. It replaces the fixed test interrupt generator with CHANNELS external sources plus one built-in periodic timer source, and has per-channel enable and edge/level mode. It resolves priority and drives the processor's `irq`/`ivec`/`iack` handshake. Software reaches it as an I/O slave on the same `io_rd`/`io_wr` strobes the MCU decodes for other peripherals.

## Interface
- `WIDTH`, 18: processor data width; must be ≥ CHANNELS+1 and ≥ TBITS.
- `CHANNELS`, 4: external sources, 1..14. Channel 0 is the timer; external `src[k]` is channel k+1.
- `TBITS`, 16: timer counter width.

- `clk` in 1: single clock.
- `arst` in 1: asynchronous, active-high reset.
- `io_rd` in 1: I/O read strobe, already decoded for this block.
- `io_wr` in 1: I/O write strobe, already decoded for this block.
- `io_addr` in 3: register select.
- `din` in WIDTH: write data.
- `io_dout` out WIDTH: read data, combinational. It is 0 when `io_rd`=0.
- `src` in CHANNELS: interrupt sources. They are already synchronous to `clk`; any CDC is done upstream.
- `irq` out 1: interrupt request, registered.
- `ivec` out 4: vector = channel+1, registered. 0 means none.
- `iack` in 1: one-cycle interrupt acknowledge from the CPU.

## Operation
- Registers, N = CHANNELS+1 bits where a field holds one bit per channel:
  - 0 EN: R/W, N bits, 1 = channel enabled.
  - 1 MODE: R/W, N bits, 1 = edge, 0 = level. Bit 0 is ignored; the timer is always edge.
  - 2 PEND: read gives the pending vector. Writing 1s clears the corresponding edge-mode pending bits (W1C).
  - 3 RELOAD: R/W, TBITS bits. A write also loads the counter.
  - 4 TCNT: read-only current timer count.
  - 5 CTRL: R/W. Bit 0 is timer run; bit 1 is the global enable GIE.
  - 6–7 read 0; writes to them are ignored.
- Unused upper bits read 0.
- Pending logic:
  - Edge channel: a rising edge of `src` (compared with the previous-cycle sample) sets its pending bit. The bit stays set until iack for that vector or a W1C write.
  - Level channel: the pending bit equals the registered `src` level. W1C and iack have no effect on it.
  - Timer: while run=1 the counter decrements every cycle. At 0 it reloads from RELOAD and sets pending[0]. Period = RELOAD+1 cycles.
- Arbiter states:
  - IDLE: `irq`=0. If GIE and (PEND & EN) is nonzero, go to REQ. `ivec` is set to the lowest set index + 1, so channel 0 (the timer) has the highest priority.
  - REQ: `irq`=1 and `ivec` is frozen. Masking the channel, clearing GIE, or a W1C does not retract the request. On `iack` the edge pending bit of channel `ivec`−1 is cleared, and the next state is IDLE with `irq`=0 and `ivec`=0.
- `iack` while in IDLE is ignored.

## Timing
- Reset values: `irq`=0, `ivec`=0, `io_dout`=0, EN=0, MODE=0, PEND=0, CTRL=0, RELOAD all ones, counter=0, source history=0.
- Source edge at cycle n: pending set at the n+1 clock edge, `irq` high after the n+2 clock edge.
- `irq` is low for at least one cycle after `iack` before re-asserting. A level source still high re-raises in the cycle after that.
- Same-cycle set and clear of one pending bit (edge with iack or W1C, or timer expiry with W1C): set wins.
- A RELOAD write in the same cycle as expiry: the counter loads the written value and pending[0] is still set.
- A register write takes effect at the next clock edge. The arbiter sees the new EN, GIE and MODE in the same cycle the timer and pending logic do.
- `arst` mid-request drops `irq` asynchronously. Nothing pending survives reset.
- Implementation target: about 200 lines of RTL.

## Test plan
- Reset, then EN=0x1F, GIE=1, MODE=0x1E. Pulse `src[1]` for one cycle → `irq`=1 with `ivec`=3 two cycles later. `iack` → `irq`=0, PEND=0.
- Edges on `src[0]` and `src[3]` in the same cycle → `ivec`=2 first. After `iack`, `irq` stays low one cycle, then re-asserts with `ivec`=5.
- `src[2]` in level mode held high → after `iack`, `irq` re-asserts with `ivec`=4. Drop `src[2]` and wait two cycles → PEND bit 3 reads 0 and `irq` stays low.
- RELOAD=9, run=1, EN bit 0=1 → pending[0] sets every 10 cycles and `ivec`=1. A W1C to PEND bit 0 in the expiry cycle leaves the bit set.
- `irq` high with `ivec`=2, then EN←0 → `irq` holds until `iack`. Pulse `arst` during a separate request → `irq`=0 and all registers read their reset values.
